// File: rtl/alu_dual_lane_pipe.sv
// Three-stage dual-lane ALU: pre-add -> multiply -> post-add/concat, one global stall.
// ALU_SAT_EN: clamp overflowing post-add results instead of wrapping.
// ctrl bits: [14] pre_x_en [13] pre_x_sub [12] pre_y_en [11] pre_y_sub
//            [10] mul_x_en [9:7] mul_x_sel [6] mul_y_en [5:3] mul_y_sel
//            [2] post_en [1] post_sub [0] post_sel
module alu_dual_lane_pipe #(
  parameter int WIDTH = 8,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [14:0]      ctrl,
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] y0,
  input  logic [WIDTH-1:0] y1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] result,
  output logic             ovf
);

  localparam int PW = WIDTH + 1;
  localparam int MW = 2 * WIDTH + 2;
  localparam int RW = 2 * WIDTH + 3;
  localparam int HW = OUT_W / 2;

  localparam logic signed [PW-1:0] ONE_P = {{(PW-1){1'b0}}, 1'b1};

  logic adv;
  logic take;

  assign adv      = !out_valid | out_ready;
  assign in_ready = adv & !flush;
  assign take     = in_valid & in_ready;

  // ---------------- stage 1: pre-add and operand select ----------------
  logic signed [PW-1:0] x0_e, x1_e, y0_e, y1_e;
  logic signed [PW-1:0] px_c, py_c, opx_c, opy_c;

  assign x0_e = {x0[WIDTH-1], x0};
  assign x1_e = {x1[WIDTH-1], x1};
  assign y0_e = {y0[WIDTH-1], y0};
  assign y1_e = {y1[WIDTH-1], y1};

  always_comb begin
    px_c = x0_e;
    if (ctrl[14]) px_c = ctrl[13] ? (x0_e - x1_e) : (x0_e + x1_e);
    py_c = y0_e;
    if (ctrl[12]) py_c = ctrl[11] ? (y0_e - y1_e) : (y0_e + y1_e);
  end

  // Multiplier operands are chosen here so only W+1-bit values cross stage 1.
  always_comb begin
    opx_c = '0;
    case (ctrl[9:7])
      3'd0:    opx_c = x0_e;
      3'd1:    opx_c = x1_e;
      3'd2:    opx_c = px_c;
      3'd3:    opx_c = y1_e;
      3'd4:    opx_c = ONE_P;
      default: opx_c = '0;
    endcase
    opy_c = '0;
    case (ctrl[5:3])
      3'd0:    opy_c = y0_e;
      3'd1:    opy_c = y1_e;
      3'd2:    opy_c = py_c;
      3'd3:    opy_c = x1_e;
      3'd4:    opy_c = ONE_P;
      default: opy_c = '0;
    endcase
  end

  logic                 s1_valid;
  logic signed [PW-1:0] s1_px, s1_py, s1_opx, s1_opy;
  logic                 s1_mx_en, s1_my_en;
  logic [2:0]           s1_post;

  // ---------------- stage 2: multiply ----------------
  logic signed [MW-1:0] px_w, py_w, opx_w, opy_w, mx_c, my_c;

  assign px_w  = {{(MW-PW){s1_px[PW-1]}}, s1_px};
  assign py_w  = {{(MW-PW){s1_py[PW-1]}}, s1_py};
  assign opx_w = {{(MW-PW){s1_opx[PW-1]}}, s1_opx};
  assign opy_w = {{(MW-PW){s1_opy[PW-1]}}, s1_opy};
  assign mx_c  = s1_mx_en ? (px_w * opx_w) : px_w;
  assign my_c  = s1_my_en ? (py_w * opy_w) : py_w;

  logic                 s2_valid;
  logic signed [MW-1:0] s2_mx, s2_my;
  logic                 s2_post_en, s2_post_sub, s2_post_sel;

  // ---------------- stage 3: post-add / concat ----------------
  logic signed [RW-1:0]   mx_r, my_r, addend, r_c;
  logic [RW-OUT_W:0]      r_hi;
  logic                   fits;
  logic [OUT_W-1:0]       res_c;
  logic                   ovf_c;

  assign mx_r   = {s2_mx[MW-1], s2_mx};
  assign my_r   = {s2_my[MW-1], s2_my};
  assign addend = s2_post_sel ? '0 : my_r;
  assign r_c    = s2_post_sub ? (mx_r - addend) : (mx_r + addend);
  assign r_hi   = r_c[RW-1:OUT_W-1];
  assign fits   = (&r_hi) | ~(|r_hi);

  always_comb begin
    ovf_c = 1'b0;
    res_c = {s2_my[HW-1:0], s2_mx[HW-1:0]};
    if (s2_post_en) begin
      ovf_c = !fits;
`ifdef ALU_SAT_EN
      if (fits)              res_c = r_c[OUT_W-1:0];
      else if (r_c[RW-1])    res_c = {1'b1, {(OUT_W-1){1'b0}}};
      else                   res_c = {1'b0, {(OUT_W-1){1'b1}}};
`else
      res_c = r_c[OUT_W-1:0];
`endif
    end
  end

  // Valids: flush wins over stall and over new input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else if (flush) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else if (adv) begin
      s1_valid  <= take;
      s2_valid  <= s1_valid;
      out_valid <= s2_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_px       <= '0;
      s1_py       <= '0;
      s1_opx      <= '0;
      s1_opy      <= '0;
      s1_mx_en    <= 1'b0;
      s1_my_en    <= 1'b0;
      s1_post     <= '0;
      s2_mx       <= '0;
      s2_my       <= '0;
      s2_post_en  <= 1'b0;
      s2_post_sub <= 1'b0;
      s2_post_sel <= 1'b0;
      result      <= '0;
      ovf         <= 1'b0;
    end else if (adv) begin
      s1_px       <= px_c;
      s1_py       <= py_c;
      s1_opx      <= opx_c;
      s1_opy      <= opy_c;
      s1_mx_en    <= ctrl[10];
      s1_my_en    <= ctrl[6];
      s1_post     <= ctrl[2:0];
      s2_mx       <= mx_c;
      s2_my       <= my_c;
      s2_post_en  <= s1_post[2];
      s2_post_sub <= s1_post[1];
      s2_post_sel <= s1_post[0];
      result      <= res_c;
      ovf         <= ovf_c;
    end
  end

endmodule

// File: tb/tb_alu_dual_lane_pipe.sv
// Directed bench for alu_dual_lane_pipe (WIDTH=8, OUT_W=16); expectations follow ALU_SAT_EN.
module tb_alu_dual_lane_pipe;

  localparam int WIDTH = 8;
  localparam int OUT_W = 16;
  localparam int NV    = 9;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, ovf;
  logic [14:0] ctrl;
  logic [7:0]  x0, x1, y0, y1;
  logic [15:0] result;

  int vectors     = 0;
  int miscompares = 0;

  logic [14:0] v_ctrl [NV];
  logic [7:0]  v_x0 [NV], v_x1 [NV], v_y0 [NV], v_y1 [NV];
  logic [15:0] v_res [NV];
  logic        v_ovf [NV];
  string       v_name [NV];

  always #5 clk = ~clk;

  alu_dual_lane_pipe #(.WIDTH(WIDTH), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .ctrl(ctrl), .x0(x0), .x1(x1), .y0(y0), .y1(y1),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .ovf(ovf)
  );

  function automatic logic [14:0] mk(input logic pxe, pxs, pye, pys, input logic mxe,
                                     input logic [2:0] mxs, input logic mye,
                                     input logic [2:0] mys, input logic pe, ps, pl);
    return {pxe, pxs, pye, pys, mxe, mxs, mye, mys, pe, ps, pl};
  endfunction

  task automatic set_vec(input int i, input string n, input logic [14:0] c,
                         input logic [7:0] a0, a1, b0, b1,
                         input logic [15:0] r, input logic o);
    v_name[i] = n; v_ctrl[i] = c; v_x0[i] = a0; v_x1[i] = a1; v_y0[i] = b0; v_y1[i] = b1;
    v_res[i] = r; v_ovf[i] = o;
  endtask

  task automatic load_vectors;
    set_vec(0, "add_mul",    mk(1,0,1,1, 1,3'd4, 1,3'd2, 1,0,0), 8'd3, 8'd4, 8'd10, 8'd2, 16'd71, 1'b0);
    set_vec(1, "sub_mul",    mk(0,0,0,0, 1,3'd0, 1,3'd3, 1,1,0), 8'hFB, 8'd7, 8'd6, 8'd0, 16'hFFEF, 1'b0);
    set_vec(2, "concat",     mk(0,0,0,0, 0,3'd0, 0,3'd0, 0,0,0), 8'h12, 8'h55, 8'h34, 8'h66, 16'h3412, 1'b0);
    set_vec(3, "concat_neg", mk(1,0,0,0, 0,3'd0, 1,3'd4, 0,0,0), 8'hF0, 8'h01, 8'h8C, 8'h77, 16'h8CF1, 1'b0);
`ifdef ALU_SAT_EN
    set_vec(4, "pos_ovf",    mk(1,0,0,0, 1,3'd2, 0,3'd0, 1,0,1), 8'd127, 8'd127, 8'd0, 8'd0, 16'h7FFF, 1'b1);
    set_vec(5, "neg_ovf",    mk(0,0,1,0, 0,3'd0, 1,3'd2, 1,1,0), 8'd0, 8'd0, 8'h80, 8'h80, 16'h8000, 1'b1);
    set_vec(7, "rsv_y_ovf",  mk(1,0,0,0, 1,3'd3, 1,3'd5, 1,1,0), 8'h80, 8'h80, 8'd1, 8'h80, 16'h7FFF, 1'b1);
`else
    set_vec(4, "pos_ovf",    mk(1,0,0,0, 1,3'd2, 0,3'd0, 1,0,1), 8'd127, 8'd127, 8'd0, 8'd0, 16'hFC04, 1'b1);
    set_vec(5, "neg_ovf",    mk(0,0,1,0, 0,3'd0, 1,3'd2, 1,1,0), 8'd0, 8'd0, 8'h80, 8'h80, 16'h0000, 1'b1);
    set_vec(7, "rsv_y_ovf",  mk(1,0,0,0, 1,3'd3, 1,3'd5, 1,1,0), 8'h80, 8'h80, 8'd1, 8'h80, 16'h8000, 1'b1);
`endif
    set_vec(6, "max_fit",    mk(1,0,0,0, 1,3'd3, 1,3'd4, 1,1,0), 8'h80, 8'h80, 8'd1, 8'h80, 16'h7FFF, 1'b0);
    set_vec(8, "rsv_x",      mk(0,0,0,0, 1,3'd5, 1,3'd4, 1,0,0), 8'd50, 8'd0, 8'd9, 8'd0, 16'd9, 1'b0);
  endtask

  task automatic drive_vec(input int i);
    in_valid = 1'b1; ctrl = v_ctrl[i];
    x0 = v_x0[i]; x1 = v_x1[i]; y0 = v_y0[i]; y1 = v_y1[i];
  endtask

  task automatic drive_concat(input logic [7:0] a, input logic [7:0] b);
    in_valid = 1'b1; ctrl = '0; x0 = a; x1 = 8'h00; y0 = b; y1 = 8'h00;
  endtask

  task automatic go_idle;
    in_valid = 1'b0;
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    vectors++; if (result !== 16'h0000) begin miscompares++; $display("FAIL reset_result: got %h expected 0000", result); end
    vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    #10 rst_n = 1'b1;
    next_cycle;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL post_reset_empty: got %b expected 0", out_valid); end
  endtask

  task automatic test_single_ops;
    for (int i = 0; i < NV; i++) begin
      drive_vec(i);
      #1;
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL %s_in_ready: got %b expected 1", v_name[i], in_ready); end
      next_cycle;
      go_idle;
      for (int k = 1; k < 3; k++) begin
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL %s_early_valid: cycle %0d got %b expected 0", v_name[i], k, out_valid); end
        next_cycle;
      end
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL %s_valid: got %b expected 1", v_name[i], out_valid); end
      vectors++; if (result !== v_res[i]) begin miscompares++; $display("FAIL %s_result: got %h expected %h", v_name[i], result, v_res[i]); end
      vectors++; if (ovf !== v_ovf[i]) begin miscompares++; $display("FAIL %s_ovf: got %b expected %b", v_name[i], ovf, v_ovf[i]); end
      next_cycle;
    end
  endtask

  task automatic test_back_to_back;
    for (int c = 0; c <= NV + 2; c++) begin
      if (c >= 3) begin
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid: cycle %0d got %b expected 1", c, out_valid); end
        vectors++; if (result !== v_res[c-3]) begin miscompares++; $display("FAIL b2b_%s: got %h expected %h", v_name[c-3], result, v_res[c-3]); end
      end
      if (c < NV) drive_vec(c); else go_idle;
      #1;
      if (c < NV) begin
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_in_ready: cycle %0d got %b expected 1", c, in_ready); end
      end
      next_cycle;
    end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_drained: got %b expected 0", out_valid); end
  endtask

  task automatic test_backpressure;
    logic [15:0] exp_q [4];
    int          nxt, got;
    logic        acc;
    logic [7:0]  a, b;
    for (int k = 0; k < 4; k++) begin
      a = 8'h10 + 8'(k); b = 8'hC0 + 8'(k);
      exp_q[k] = {b, a};
    end
    nxt = 0; got = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      a = 8'h10 + 8'(nxt); b = 8'hC0 + 8'(nxt);
      if (nxt < 4) drive_concat(a, b); else go_idle;
      #1;
      if (c >= 3) begin
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready: cycle %0d got %b expected 0", c, in_ready); end
        vectors++; if (out_valid !== 1'b1 || result !== exp_q[0]) begin miscompares++; $display("FAIL bp_hold: cycle %0d got %b/%h expected 1/%h", c, out_valid, result, exp_q[0]); end
      end
      acc = in_valid & in_ready;
      next_cycle;
      if (acc) nxt++;
    end
    vectors++; if (nxt !== 3) begin miscompares++; $display("FAIL bp_accepted: got %0d expected 3", nxt); end
    out_ready = 1'b1;
    for (int c = 0; c < 20 && got < 4; c++) begin
      a = 8'h10 + 8'(nxt); b = 8'hC0 + 8'(nxt);
      if (nxt < 4) drive_concat(a, b); else go_idle;
      #1;
      acc = in_valid & in_ready;
      if (out_valid === 1'b1) begin
        vectors++; if (result !== exp_q[got]) begin miscompares++; $display("FAIL bp_order_%0d: got %h expected %h", got, result, exp_q[got]); end
        got++;
      end
      next_cycle;
      if (acc) nxt++;
    end
    go_idle;
    vectors++; if (got !== 4) begin miscompares++; $display("FAIL bp_count: got %0d expected 4", got); end
    for (int c = 0; c < 4; c++) begin
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_dup: cycle %0d got %b expected 0", c, out_valid); end
      next_cycle;
    end
  endtask

  task automatic test_flush;
    out_ready = 1'b1;
    drive_vec(0); next_cycle;
    drive_vec(1); next_cycle;
    drive_vec(2); flush = 1'b1;
    #1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL flush_in_ready: got %b expected 0", in_ready); end
    next_cycle;
    flush = 1'b0; go_idle;
    for (int c = 0; c < 5; c++) begin
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_dropped: cycle %0d got %b expected 0", c, out_valid); end
      next_cycle;
    end
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin drive_vec(c); next_cycle; end
    go_idle;
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL flush_stall_setup: got %b expected 1", out_valid); end
    flush = 1'b1; in_valid = 1'b1;
    next_cycle;
    flush = 1'b0; go_idle; out_ready = 1'b1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_over_stall: got %b expected 0", out_valid); end
    for (int c = 0; c < 4; c++) begin
      next_cycle;
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_stall_dropped: cycle %0d got %b expected 0", c, out_valid); end
    end
  endtask

  task automatic test_async_reset;
    out_ready = 1'b0;
    drive_vec(4); next_cycle;
    drive_vec(0); next_cycle;
    drive_vec(1); next_cycle;
    go_idle;
    vectors++; if (out_valid !== 1'b1 || ovf !== 1'b1) begin miscompares++; $display("FAIL arst_setup: got %b/%b expected 1/1", out_valid, ovf); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL arst_out_valid: got %b expected 0", out_valid); end
    vectors++; if (result !== 16'h0000) begin miscompares++; $display("FAIL arst_result: got %h expected 0000", result); end
    vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL arst_ovf: got %b expected 0", ovf); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL arst_in_ready: got %b expected 1", in_ready); end
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      next_cycle;
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL arst_empty: cycle %0d got %b expected 0", c, out_valid); end
    end
    drive_vec(8);
    next_cycle;
    go_idle;
    for (int k = 1; k < 3; k++) begin
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL arst_early: cycle %0d got %b expected 0", k, out_valid); end
      next_cycle;
    end
    vectors++; if (out_valid !== 1'b1 || result !== v_res[8]) begin miscompares++; $display("FAIL arst_first_op: got %b/%h expected 1/%h", out_valid, result, v_res[8]); end
    next_cycle;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    ctrl = '0; x0 = '0; x1 = '0; y0 = '0; y1 = '0;
    load_vectors;
    test_reset;
    test_single_ops;
    test_back_to_back;
    test_backpressure;
    test_flush;
    test_async_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_dual_lane_pipe.md
Name: alu_dual_lane_pipe

Overview:
- Parametrised, 3-stage pipelined dual-lane ALU datapath driven by `alu_pkg::alu_ctrl_t`.
- Each lane has a pre-adder and a multiplier with operand select. The two lanes then feed a shared post-adder or a concat path.
- Generalises the fixed-width combinational lane to WIDTH/OUT_W operands. Adds a valid/ready handshake, flush, and an overflow flag.
- Sits between the operand/control sequencer and the result writeback.

Parameters:
- WIDTH, 8, signed input operand width (≥2).
- OUT_W, 16, result width; must be even and ≤ 2*WIDTH+3.

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- flush  in  1  sync clear of all pipeline valids
- in_valid  in  1  operand/ctrl valid
- in_ready  out  1  block accepts this cycle
- ctrl  in  alu_ctrl_t (15)  per-operation control
- x0, x1, y0, y1  in  WIDTH each  signed operands
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- result  out  OUT_W  signed result
- ovf  out  1  result was wrapped (or saturated), qualified by out_valid

Behaviour:
- Reset: the only reset is rst_n, asynchronous and active-low; clock is clk. All stage valids, result, ovf and data regs are 0. in_ready follows its equation, so it reads 1 in reset.
- Advance enable: adv = !out_valid | out_ready. This is one global stall; all stages move together.
- in_ready = adv & !flush. A transfer happens when in_valid & in_ready.
- Latency: exactly 3 adv cycles from acceptance to out_valid. Throughput is 1/cycle. Results stay in order.
- Stage 1, pre-add (W+1 bits, sign-extended). ctrl is registered alongside the data.
  - px = pre_x_en ? (pre_x_sub ? x0-x1 : x0+x1) : x0
  - py = pre_y_en ? (pre_y_sub ? y0-y1 : y0+y1) : y0
- Stage 2, multiply (2W+2 bits, signed).
  - X operand by mul_x_sel: 0 x0, 1 x1, 2 px (square), 3 y1, 4 +1, 5–7 zero.
  - Y operand by mul_y_sel: 0 y0, 1 y1, 2 py, 3 x1, 4 +1, 5–7 zero.
  - mx = mul_x_en ? px*opx : sext(px); my likewise.
- Stage 3, post (2W+3 bits full precision).
  - post_en=1: r = mx ± (post_sel ? 0 : my); post_sub selects −.
  - post_en=0: r = {my[OUT_W/2-1:0], mx[OUT_W/2-1:0]} (concat, no sign extension); ovf=0.
  - result = r[OUT_W-1:0]. ovf=1 iff r does not fit in signed OUT_W (post_en=1 only).
- Output hold: out_valid & !out_ready keeps result/ovf stable and in_ready=0.
- flush: synchronous; clears all three stage valids next edge, including out_valid. A concurrent in_valid is dropped (in_ready=0). flush overrides out_ready.
- Reset mid-operation: in-flight ops are discarded and outputs drop to 0 immediately (async).
- Reserved mul sel values (5–7) are not errors; they select zero.

Optional Feature:
- Macro ALU_SAT_EN.
- Defined: post_en=1 results that overflow OUT_W clamp to +2^(OUT_W-1)-1 or −2^(OUT_W-1); ovf=1 on clamp. Concat mode is unaffected.
- Undefined: results wrap (truncate) as above; ovf still reports the overflow.

Test Plan:
- x0=3,x1=4 add, mul_x sel4; y0=10,y1=2 sub, mul_y sel2; post add, sel0 → result=71 (7+64), ovf=0, 3 cycles after accept.
- post_en=0, mul_en=0, pre_en=0, x0=0x12, y0=0x34 → result=0x3412, ovf=0.
- out_ready=0 for 6 cycles while in_valid held with 4 ops → exactly 3 accepted, in_ready=0 until out_ready. All 4 results then emerge in order with no loss or duplication.
- x0=x1=127 add, mul_x sel2, post add sel1 → r=64516: result=0xFC04, ovf=1. With ALU_SAT_EN: result=0x7FFF, ovf=1.
- flush asserted with 2 ops in flight and in_valid=1 → next cycle out_valid=0, no result for dropped ops, in_ready=0 that cycle.
- rst_n low for 1 ns mid-stream (between edges) → out_valid, result, ovf read 0 before the next clk edge; after release the pipeline is empty and the first new op appears 3 cycles after accept. Also: mul_x_sel=5 with mul_x_en=1 → result contribution 0.
